lsu_master: RTL and testbench



---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/lsu_master.sv | 194 +++++++++++++++++++
 tb/tb_lsu_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the KGP-RISC load/store initiator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

    // Access size encodings as carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RSP  = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    // True when the request cannot be serviced: illegal size code, or an
    // address not naturally aligned to the access size.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: addr_lo/size/sign_ext select the lane and extension; rdata is the
// word read from memory, wdata the right-aligned store data; load_data is the
// extended load result, merge_data the word to write back.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data  = '0;
        merge_data = rdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: begin
                load_data  = rdata;
                merge_data = wdata;
            end
            default: begin
                load_data  = '0;
                merge_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator driving a word-addressed data memory; byte/half stores via read-modify-write.
// Latency: load 1+RD_LAT, word store 2, sub-word store 2+RD_LAT, error 1 cycle(s) from accept to rsp_valid.
// Backpressure: one request outstanding (req_ready only in IDLE); response held stable until rsp_ready.
// Ports: req_* request channel (valid/ready), rsp_* response channel (valid/ready),
// mem_* memory port (mem_rdata sampled on the last mem_read cycle).
// Optional: define LSU_STATS_EN to add 16-bit wrapping counters stat_loads/stat_stores/stat_errs.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    // Read-latency down-counter; RD_LAT is at most 4, so two bits suffice.
    localparam int              CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    lsu_lane_align u_align (
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (sgn_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    // Stores and errors return zero data, so clear it up front.
                    rdata_d = '0;
                    cnt_d   = CNT_INIT;
                    if (lsu_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ERR;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        // wdata_q becomes the full merged word written next cycle.
                        wdata_d = merge_data;
                        state_d = WR;
                    end else begin
                        rdata_d = load_data;
                        state_d = RSP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR: begin
                state_d = RSP;
            end
            RSP, ERR: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state and latched registers, so a reset
    // drops mem_write in the same instant it is asserted.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP) || (state_q == ERR);
    assign rsp_err   = (state_q == ERR);
    assign rsp_rdata = rdata_q;
    assign mem_read  = (state_q == RD);
    assign mem_write = (state_q == WR);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = wdata_q;

`ifdef LSU_STATS_EN
    logic [15:0] loads_q, loads_d;
    logic [15:0] stores_q, stores_d;
    logic [15:0] errs_q, errs_d;

    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        errs_d   = errs_q;
        if (rsp_valid && rsp_ready) begin
            if (state_q == ERR) begin
                errs_d = errs_q + 16'd1;
            end else if (we_q) begin
                stores_d = stores_q + 16'd1;
            end else begin
                loads_d = loads_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            errs_q   <= errs_d;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: one instance at RD_LAT=1 and one at RD_LAT=3, each with its own memory.
// Latency: responses are scored against expected cycle counts from the accept edge.
// Backpressure: rsp_ready is held low on one transaction to check response stability.
module tb_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_signed, rsp_ready;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        sel3;

    logic        req_ready1, rsp_valid1, rsp_err1, mem_read1, mem_write1;
    logic [31:0] rsp_rdata1, mem_wdata1, mem_rdata1;
    logic [9:0]  mem_addr1;
    logic        req_ready3, rsp_valid3, rsp_err3, mem_read3, mem_write3;
    logic [31:0] rsp_rdata3, mem_wdata3, mem_rdata3;
    logic [9:0]  mem_addr3;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];

    always #5 clk = ~clk;

`ifdef LSU_STATS_EN
    logic [15:0] sl1, ss1, se1, sl3, ss3, se3;
`endif

    lsu_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel3), .req_ready(req_ready1),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_rdata(mem_rdata1)
`ifdef LSU_STATS_EN
        , .stat_loads(sl1), .stat_stores(ss1), .stat_errs(se1)
`endif
    );

    lsu_master #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel3), .req_ready(req_ready3),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_read(mem_read3), .mem_write(mem_write3), .mem_rdata(mem_rdata3)
`ifdef LSU_STATS_EN
        , .stat_loads(sl3), .stat_stores(ss3), .stat_errs(se3)
`endif
    );

    // Simple word memories: combinational read, write on the clock edge.
    always @(posedge clk) if (mem_write1) mem1[mem_addr1] <= mem_wdata1;
    always @(posedge clk) if (mem_write3) mem3[mem_addr3] <= mem_wdata3;
    assign mem_rdata1 = mem1[mem_addr1];
    assign mem_rdata3 = mem3[mem_addr3];

    // View of whichever instance is under test.
    logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_read, o_mem_write;
    logic [31:0] o_rsp_rdata, o_mem_wdata;
    logic [9:0]  o_mem_addr;
    assign o_req_ready = sel3 ? req_ready3 : req_ready1;
    assign o_rsp_valid = sel3 ? rsp_valid3 : rsp_valid1;
    assign o_rsp_err   = sel3 ? rsp_err3   : rsp_err1;
    assign o_rsp_rdata = sel3 ? rsp_rdata3 : rsp_rdata1;
    assign o_mem_read  = sel3 ? mem_read3  : mem_read1;
    assign o_mem_write = sel3 ? mem_write3 : mem_write1;
    assign o_mem_wdata = sel3 ? mem_wdata3 : mem_wdata1;
    assign o_mem_addr  = sel3 ? mem_addr3  : mem_addr1;

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [9:0]  wr_addr_seen = '0;
    logic [31:0] wr_data_seen = '0;

    always @(posedge clk) begin
        if (o_mem_read)  rd_cnt <= rd_cnt + 1;
        if (o_mem_write) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= o_mem_addr;
            wr_data_seen <= o_mem_wdata;
        end
        if ((mem_read1 && mem_write1) || (mem_read3 && mem_write3)) both_cnt <= both_cnt + 1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // response handshake edge, so the next call tests back-to-back acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input int hold, input string tag);
        exp_t e;
        int   lat;
        int   rd0;
        int   wr0;
        check({tag, " req_ready"}, {31'b0, o_req_ready}, 32'd1);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        rsp_ready  = (hold == 0);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        sb.push_back('{exp_rdata, exp_err, exp_lat, exp_rd, exp_wr});
        @(posedge clk);
        @(negedge clk);
        // Scramble the request so only the latched copy can be correct.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = ~size;
        req_signed = ~sgn;
        req_addr   = ~addr;
        req_wdata  = 32'h0BAD_F00D;
        lat = 1;
        while (!o_rsp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, " rsp_valid"}, {31'b0, o_rsp_valid}, 32'd1);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " rdata"}, o_rsp_rdata, e.rdata);
        check({tag, " err"}, {31'b0, o_rsp_err}, {31'b0, e.err});
        check({tag, " mem_read cycles"}, rd_cnt - rd0, e.rd);
        check({tag, " mem_write cycles"}, wr_cnt - wr0, e.wr);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " held valid"}, {31'b0, o_rsp_valid}, 32'd1);
            check({tag, " held rdata"}, o_rsp_rdata, e.rdata);
            check({tag, " held req_ready"}, {31'b0, o_req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " rsp released"}, {31'b0, o_rsp_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, {31'b0, o_req_ready}, 32'd1);
        check({tag, " rsp_valid"}, {31'b0, o_rsp_valid}, 32'd0);
        check({tag, " rsp_err"}, {31'b0, o_rsp_err}, 32'd0);
        check({tag, " rsp_rdata"}, o_rsp_rdata, 32'd0);
        check({tag, " mem_read"}, {31'b0, o_mem_read}, 32'd0);
        check({tag, " mem_write"}, {31'b0, o_mem_write}, 32'd0);
        check({tag, " mem_addr"}, {22'b0, o_mem_addr}, 32'd0);
        check({tag, " mem_wdata"}, o_mem_wdata, 32'd0);
    endtask

    initial begin
        int wr0;
        rst        = 1'b0;
        sel3       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        #2;
        check_reset_outputs("reset");
        check("reset dut3 req_ready", {31'b0, req_ready3}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Word store then load back.
        issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 0, "wst");
        check("wst mem_addr", {22'b0, wr_addr_seen}, 32'd4);
        check("wst mem_wdata", wr_data_seen, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 0, "wld");

        // Extension cases on 0x80FF7F01.
        issue(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1, 0, "wst2");
        issue(1'b0, 2'b00, 1'b1, 12'h012, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1, 0, 0, "lb s 012");
        issue(1'b0, 2'b00, 1'b0, 12'h012, 32'h0, 32'h000000FF, 1'b0, 2, 1, 0, 0, "lb u 012");
        issue(1'b0, 2'b01, 1'b1, 12'h012, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 0, "lh s 012");
        issue(1'b0, 2'b01, 1'b0, 12'h010, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0, 0, "lh u 010");
        issue(1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0, 0, "lb s 011");
        issue(1'b0, 2'b00, 1'b1, 12'h013, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 0, "lb s 013");

        // Read-modify-write stores.
        issue(1'b1, 2'b10, 1'b0, 12'h010, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 0, "wst3");
        issue(1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1, 1, 0, "sb 011");
        check("sb mem_addr", {22'b0, wr_addr_seen}, 32'd4);
        check("sb merged", wr_data_seen, 32'h1122AA44);
        issue(1'b1, 2'b01, 1'b0, 12'h012, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1, 0, "sh 012");
        check("sh merged", wr_data_seen, 32'hBEEFAA44);

        // Errors: no memory access, response one cycle after accept.
        issue(1'b0, 2'b01, 1'b0, 12'h013, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, "err lh 013");
        issue(1'b1, 2'b10, 1'b0, 12'h012, 32'h55555555, 32'h0, 1'b1, 1, 0, 0, 0, "err sw 012");
        issue(1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0, "err size11");

        // Backpressure: response held for five cycles.
        issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 5, "bp load");

        // Reset while the byte store is in its read phase.
        check("rst req_ready", {31'b0, o_req_ready}, 32'd1);
        wr0        = wr_cnt;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 12'h010;
        req_wdata  = 32'h00000055;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst in RD mem_read", {31'b0, o_mem_read}, 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid-op reset");
        repeat (3) @(negedge clk);
        check("mid-op reset writes", wr_cnt - wr0, 32'd0);
        check("mid-op reset rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 0, "post-rst load");

        // RD_LAT=3 instance.
        sel3 = 1'b1;
        @(negedge clk);
        issue(1'b1, 2'b10, 1'b0, 12'h020, 32'h12345678, 32'h0, 1'b0, 2, 0, 1, 0, "l3 wst");
        check("l3 wst mem_addr", {22'b0, wr_addr_seen}, 32'd8);
        issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h12345678, 1'b0, 4, 3, 0, 0, "l3 wld");
        issue(1'b1, 2'b00, 1'b0, 12'h021, 32'h0000009A, 32'h0, 1'b0, 5, 3, 1, 0, "l3 sb");
        check("l3 sb merged", wr_data_seen, 32'h12349A78);
        issue(1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 32'h00001234, 1'b0, 4, 3, 0, 0, "l3 lh");
        issue(1'b0, 2'b00, 1'b1, 12'h021, 32'h0, 32'hFFFFFF9A, 1'b0, 4, 3, 0, 0, "l3 lb");

        check("read and write never together", both_cnt, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
